// File: rtl/branch_compare_unit.sv
// Multi-cycle branch comparator: scans two operands one CHUNK at a time from the MSB
// and resolves RISC-V branch funct3 into gt/eq/lt, taken and illegal behind valid/ready.
module branch_compare_unit #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic             taken,
    output logic             illegal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH % CHUNK != 0) begin : g_width_guard
        $error("branch_compare_unit: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              found_q, found_d;
    logic              first_gt_q, first_gt_d;
    logic              gt_q, gt_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;

    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic              chunk_diff;
    logic              chunk_gt;
    logic              finish;
    logic              res_gt;
    logic              res_eq;
    logic              res_lt;
    logic              res_illegal;

    function automatic logic branch_taken(input logic [2:0] f3, input logic g,
                                          input logic e, input logic l);
        logic t;
        case (f3)
            3'b000:          t = e;
            3'b001:          t = ~e;
            3'b100, 3'b110:  t = l;
            3'b101, 3'b111:  t = g | e;
            default:         t = 1'b0;
        endcase
        return t;
    endfunction

    assign chunk_a    = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_b    = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign chunk_diff = (chunk_a != chunk_b);
    assign chunk_gt   = (chunk_a > chunk_b);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        found_d     = found_q;
        first_gt_d  = first_gt_q;
        gt_d        = gt_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        taken_d     = taken_q;
        illegal_d   = illegal_q;
        finish      = 1'b0;
        res_gt      = 1'b0;
        res_eq      = 1'b0;
        res_lt      = 1'b0;
        res_illegal = (op_q[2:1] == 2'b01);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    // Flipping both sign bits maps two's complement order onto unsigned order.
                    if (!op[1]) begin
                        a_d[WIDTH-1] = ~a[WIDTH-1];
                        b_d[WIDTH-1] = ~b[WIDTH-1];
                    end
                    idx_d      = IDXW'(NCHUNK - 1);
                    found_d    = 1'b0;
                    first_gt_d = 1'b0;
                    state_d    = BUSY;
                end
            end

            BUSY: begin
                if ((EARLY_EXIT != 0) && chunk_diff) begin
                    finish = 1'b1;
                    res_gt = chunk_gt;
                    res_lt = ~chunk_gt;
                end else if (idx_q == '0) begin
                    finish = 1'b1;
                    if (found_q) begin
                        res_gt = first_gt_q;
                        res_lt = ~first_gt_q;
                    end else if (chunk_diff) begin
                        res_gt = chunk_gt;
                        res_lt = ~chunk_gt;
                    end else begin
                        res_eq = 1'b1;
                    end
                end else begin
                    // Only the most significant differing chunk decides the order.
                    if (chunk_diff && !found_q) begin
                        found_d    = 1'b1;
                        first_gt_d = chunk_gt;
                    end
                    idx_d = idx_q - IDXW'(1);
                end

                if (finish) begin
                    gt_d      = res_gt;
                    eq_d      = res_eq;
                    lt_d      = res_lt;
                    illegal_d = res_illegal;
                    taken_d   = res_illegal ? 1'b0 : branch_taken(op_q, res_gt, res_eq, res_lt);
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            idx_q      <= '0;
            found_q    <= 1'b0;
            first_gt_q <= 1'b0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            lt_q       <= 1'b0;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            idx_q      <= idx_d;
            found_q    <= found_d;
            first_gt_q <= first_gt_d;
            gt_q       <= gt_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            taken_q    <= taken_d;
            illegal_q  <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign gt        = gt_q;
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign taken     = taken_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed bench for branch_compare_unit: one early-exit and one constant-time instance
// driven in lockstep, with hand-computed results and latencies.
module tb_branch_compare_unit;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_ready;

    logic in_ready_ee, out_valid_ee, gt_ee, eq_ee, lt_ee, taken_ee, illegal_ee;
    logic in_ready_ct, out_valid_ct, gt_ct, eq_ct, lt_ct, taken_ct, illegal_ct;

    int tests  = 0;
    int failed = 0;

    branch_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ee),
        .a(a), .b(b), .op(op), .out_valid(out_valid_ee), .out_ready(out_ready),
        .gt(gt_ee), .eq(eq_ee), .lt(lt_ee), .taken(taken_ee), .illegal(illegal_ee)
    );

    branch_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(0)) u_dut_ct (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ct),
        .a(a), .b(b), .op(op), .out_valid(out_valid_ct), .out_ready(out_ready),
        .gt(gt_ct), .eq(eq_ct), .lt(lt_ct), .taken(taken_ct), .illegal(illegal_ct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Result vectors are packed {gt, eq, lt, taken, illegal}.
    task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                           input logic [2:0] vop, input int k_ee, input int k_ct,
                           input logic [4:0] exp_res);
        int got_ee;
        int got_ct;
        logic [4:0] res_ee;
        logic [4:0] res_ct;
        got_ee = 0;
        got_ct = 0;
        res_ee = '0;
        res_ct = '0;
        @(negedge clk);
        a         = va;
        b         = vb;
        op        = vop;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check({tag, "_rdy"}, {in_ready_ee, in_ready_ct}, 2'b11);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a  = ~va;
        b  = va;
        op = 3'b011;
        for (int n = 1; n <= NCHUNK + 4; n++) begin
            @(posedge clk);
            #1;
            if (got_ee == 0 && out_valid_ee) begin
                got_ee = n;
                res_ee = {gt_ee, eq_ee, lt_ee, taken_ee, illegal_ee};
            end
            if (got_ct == 0 && out_valid_ct) begin
                got_ct = n;
                res_ct = {gt_ct, eq_ct, lt_ct, taken_ct, illegal_ct};
            end
        end
        check({tag, "_lat_ee"}, got_ee, k_ee);
        check({tag, "_lat_ct"}, got_ct, k_ct);
        check({tag, "_res_ee"}, res_ee, exp_res);
        check({tag, "_res_ct"}, res_ct, exp_res);
    endtask

    initial begin
        int w;
        int spurious;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rdy", {in_ready_ee, in_ready_ct}, 2'b11);
        check("reset_ov", {out_valid_ee, out_valid_ct}, 2'b00);
        check("reset_out_ee", {gt_ee, eq_ee, lt_ee, taken_ee, illegal_ee}, 5'b00000);
        check("reset_out_ct", {gt_ct, eq_ct, lt_ct, taken_ct, illegal_ct}, 5'b00000);

        run_vec("beq_eq",     32'h1234_5678, 32'h1234_5678, 3'b000, 4, 4, 5'b01010);
        run_vec("blt_sign",   32'h8000_0000, 32'h0000_0001, 3'b100, 1, 4, 5'b00110);
        run_vec("bltu_sign",  32'h8000_0000, 32'h0000_0001, 3'b110, 1, 4, 5'b10000);
        run_vec("bgeu_msb",   32'hFF00_0000, 32'h0000_0000, 3'b111, 1, 4, 5'b10010);
        run_vec("bgeu_lsb",   32'h0000_00FF, 32'h0000_00FE, 3'b111, 4, 4, 5'b10010);
        run_vec("bge_neg",    32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 1, 4, 5'b00100);
        run_vec("beq_ne",     32'h1234_5600, 32'h1234_5678, 3'b000, 4, 4, 5'b00100);
        run_vec("bltu_sticky",32'h0100_0000, 32'h00FF_FFFF, 3'b110, 1, 4, 5'b10000);
        run_vec("illegal",    32'h0000_0005, 32'h0000_0003, 3'b010, 4, 4, 5'b10001);
        run_vec("bne_eq",     32'h0000_0007, 32'h0000_0007, 3'b001, 4, 4, 5'b01000);

        // Backpressure: result must hold while out_ready stays low.
        @(negedge clk);
        a         = 32'h0000_0005;
        b         = 32'h0000_0003;
        op        = 3'b100;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid_ee && w < NCHUNK + 4) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("bp_lat", w, 4);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_ov", {out_valid_ee, out_valid_ct}, 2'b11);
            check("bp_hold_rdy", {in_ready_ee, in_ready_ct}, 2'b00);
            check("bp_hold_ee", {gt_ee, eq_ee, lt_ee, taken_ee, illegal_ee}, 5'b10000);
            check("bp_hold_ct", {gt_ct, eq_ct, lt_ct, taken_ct, illegal_ct}, 5'b10000);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ov", {out_valid_ee, out_valid_ct}, 2'b00);
        check("bp_release_rdy", {in_ready_ee, in_ready_ct}, 2'b11);
        run_vec("bp_next", 32'hCAFE_0001, 32'hCAFE_0001, 3'b000, 4, 4, 5'b01010);

        // Reset during the second BUSY cycle abandons the compare.
        @(negedge clk);
        a        = 32'h1234_5678;
        b        = 32'h1234_5678;
        op       = 3'b000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_ov", {out_valid_ee, out_valid_ct}, 2'b00);
        check("rst_mid_out_ee", {gt_ee, eq_ee, lt_ee, taken_ee, illegal_ee}, 5'b00000);
        check("rst_mid_out_ct", {gt_ct, eq_ct, lt_ct, taken_ct, illegal_ct}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_rdy", {in_ready_ee, in_ready_ct}, 2'b11);
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_ee || out_valid_ct) spurious++;
        end
        check("rst_no_spurious", spurious, 0);
        run_vec("post_rst", 32'h0000_0100, 32'h0000_0200, 3'b100, 3, 4, 5'b00110);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
